ac701_clock_reset_seq: RTL and testbench
========================================

Name: ac701_clock_reset_seq

Overview:
Reset/lock supervisor that drives the PLL reset of the board clock generator and consumes its lock indication. It pulses the PLL reset, waits for lock with a timeout and retry, and requires lock to be stable before releasing the downstream system reset. It also re-sequences on loss of lock. Runs on a free-running clock (buffered oscillator, not a PLL output) and sits between board reset logic and the clock generator / user fabric.

Parameters:
RST_PULSE_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 65535, cycles to wait for lock before re-pulsing pll_rst (>=1)
STABLE_CYCLES, 1024, cycles lock must stay continuously high before release (>=1)
CNT_WIDTH, 16, width of the shared cycle counter; must hold max(param)-1
RETRY_WIDTH, 8, width of retry_count

Ports:
clk  input  1  free-running clock; all logic on rising edge
glbl_rst  input  1  reset, asynchronous, active-high
pll_lock  input  1  PLL LOCKED, asynchronous to clk
clear_status  input  1  synchronous; clears retry_count and lock_lost
pll_rst  output  1  to PLL RST, active-high
sys_rst  output  1  downstream reset, active-high
ready  output  1  high while clocks are valid (state RUN)
retry_count  output  RETRY_WIDTH  number of lock timeouts, saturating
lock_lost  output  1  sticky: lock dropped while in RUN

Behaviour:
- Reset: glbl_rst=1 forces the following asynchronously: state=RESET_PLL, cnt=0, synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, retry_count=0, lock_lost=0.
- pll_lock passes through a 2-flop synchronizer giving lock_s. Latency is 2 edges. No other use of raw pll_lock.
- Outputs are registered. They are updated on the same edge as the state register:
  - pll_rst = (next state == RESET_PLL)
  - sys_rst = (next state != RUN)
  - ready = (next state == RUN)
  - No combinational paths from inputs to outputs.
- RESET_PLL: cnt increments each edge. When cnt == RST_PULSE_CYCLES-1, go to WAIT_LOCK with cnt=0. pll_rst is high for exactly RST_PULSE_CYCLES cycles per attempt.
- WAIT_LOCK: evaluated in priority order:
  - lock_s=1: go to STABLE, cnt=0.
  - else if cnt == LOCK_TIMEOUT-1: go to RESET_PLL, cnt=0, retry_count++ (saturates at all-ones, no wrap).
  - else: cnt++.
- STABLE: evaluated in priority order:
  - lock_s=0: go to WAIT_LOCK, cnt=0. This is a glitch; no retry increment and lock_lost unchanged.
  - else if cnt == STABLE_CYCLES-1: go to RUN.
  - else: cnt++.
- RUN: cnt is held.
  - lock_s=0: go to RESET_PLL, cnt=0, lock_lost=1.
- clear_status=1 on an edge: retry_count=0 and lock_lost=0. It has priority over a simultaneous increment or set on the same edge. The FSM is unaffected.
- glbl_rst asserted mid-operation in any state: immediate return to reset values. Counters do not resume.
- The counter never exceeds the compare value, so there is no wrap inside a state.

Test Plan:
(Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RETRY_WIDTH=8.)
1. Normal lock. Release glbl_rst, hold pll_lock=0 for 10 cycles, then 1 permanently. Required response:
   - pll_rst high exactly 4 cycles after release.
   - ready and ~sys_rst rise on the 11th rising edge counting the edge that first samples pll_lock=1.
   - retry_count=0, lock_lost=0.
2. No lock. Hold pll_lock=0. Required response:
   - pll_rst pulses 4 high / 20 low, period 24 cycles.
   - retry_count increments once per period.
   - Force 300 timeouts: retry_count stays at 255.
3. Glitch during STABLE. Drop pll_lock for 3 cycles after 5 stable cycles. Required response:
   - Return to WAIT_LOCK; ready stays 0; retry_count unchanged; no pll_rst pulse.
   - ready rises 11 edges after lock is re-asserted.
4. Loss in RUN. Drop pll_lock while ready=1. Required response:
   - On the 3rd edge after the drop: ready=0, sys_rst=1, pll_rst=1, lock_lost=1.
   - pll_rst is a 4-cycle pulse.
   - Restore lock: full sequence repeats and lock_lost stays 1.
5. clear_status coincident with the timeout edge. Required response: retry_count reads 0 afterward. clear_status in RUN with lock_lost=1 clears it while ready stays 1.
6. Asynchronous reset mid-operation. Assert glbl_rst mid-STABLE, between clock edges. Required response:
   - pll_rst=1, sys_rst=1, ready=0 before the next edge; counters and status cleared.
   - After release, the sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/ac701_clock_reset_seq.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock and
// only then releases the downstream system reset. Loss of lock re-sequences.
module ac701_clock_reset_seq #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65535,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_WIDTH        = 16,
  parameter int RETRY_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   glbl_rst,
  input  logic                   pll_lock,
  input  logic                   clear_status,
  output logic                   pll_rst,
  output logic                   sys_rst,
  output logic                   ready,
  output logic [RETRY_WIDTH-1:0] retry_count,
  output logic                   lock_lost
);

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [1:0]           lock_sync;
  logic                 lock_s;
  logic                 retry_inc;
  logic                 lost_set;

  assign lock_s = lock_sync[1];

  // pll_lock comes from the PLL's own domain, so it is only seen through this pair
  always_ff @(posedge clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_inc  = 1'b0;
    lost_set   = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = RESET_PLL;
          cnt_next   = '0;
          retry_inc  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      STABLE: begin
        // A dropout here is treated as a glitch: back to waiting, no retry counted
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = RESET_PLL;
          cnt_next   = '0;
          lost_set   = 1'b1;
        end
      end
      default: begin
        state_next = RESET_PLL;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM
  always_ff @(posedge clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      state   <= RESET_PLL;
      cnt     <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pll_rst <= (state_next == RESET_PLL);
      sys_rst <= (state_next != RUN);
      ready   <= (state_next == RUN);
    end
  end

  // clear_status wins over a same-edge increment or set
  always_ff @(posedge clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      retry_count <= '0;
      lock_lost   <= 1'b0;
    end else if (clear_status) begin
      retry_count <= '0;
      lock_lost   <= 1'b0;
    end else begin
      if (retry_inc && (retry_count != '1)) begin
        retry_count <= retry_count + RETRY_WIDTH'(1);
      end
      if (lost_set) begin
        lock_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ac701_clock_reset_seq.sv
// Directed bench for ac701_clock_reset_seq with short timing parameters;
// every check is an immediate assertion against a hand-computed value.
module tb_ac701_clock_reset_seq;

  logic       clk;
  logic       glbl_rst;
  logic       pll_lock;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] retry_count;
  logic       lock_lost;

  int errors = 0;
  int checks = 0;

  ac701_clock_reset_seq #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT    (20),
    .STABLE_CYCLES   (8),
    .CNT_WIDTH       (16),
    .RETRY_WIDTH     (8)
  ) dut (
    .clk         (clk),
    .glbl_rst    (glbl_rst),
    .pll_lock    (pll_lock),
    .clear_status(clear_status),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .retry_count (retry_count),
    .lock_lost   (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic lock, input logic clr);
    glbl_rst     = rst;
    pll_lock     = lock;
    clear_status = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyc(3);
    checkOutput("rst_pll_rst", pll_rst, 1);
    checkOutput("rst_sys_rst", sys_rst, 1);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_retry", retry_count, 0);
    checkOutput("rst_lock_lost", lock_lost, 0);

    // Normal lock: pll_rst for 4 edges, lock after 10, ready on the 11th edge
    $display("[TB] normal lock");
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      checkOutput("t1_pll_rst_pulse", pll_rst, (k < 4) ? 1 : 0);
    end
    cyc(6);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cyc(10);
    checkOutput("t1_ready_early", ready, 0);
    checkOutput("t1_sys_rst_early", sys_rst, 1);
    cyc(1);
    checkOutput("t1_ready", ready, 1);
    checkOutput("t1_sys_rst", sys_rst, 0);
    checkOutput("t1_pll_rst", pll_rst, 0);
    checkOutput("t1_retry", retry_count, 0);
    checkOutput("t1_lock_lost", lock_lost, 0);

    // Loss in RUN: seen on the 3rd edge, 4-cycle pll_rst pulse, then recover
    $display("[TB] loss in run");
    applyStimulus(1'b0, 1'b0, 1'b0);
    cyc(2);
    checkOutput("t4_ready_d2", ready, 1);
    cyc(1);
    checkOutput("t4_ready_d3", ready, 0);
    checkOutput("t4_sys_rst_d3", sys_rst, 1);
    checkOutput("t4_pll_rst_d3", pll_rst, 1);
    checkOutput("t4_lock_lost_d3", lock_lost, 1);
    for (int k = 4; k <= 7; k++) begin
      cyc(1);
      checkOutput("t4_pll_rst_pulse", pll_rst, (k < 7) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    cyc(10);
    checkOutput("t4_ready_early", ready, 0);
    cyc(1);
    checkOutput("t4_ready", ready, 1);
    checkOutput("t4_lock_lost_sticky", lock_lost, 1);

    // clear_status in RUN clears lock_lost without touching the FSM
    $display("[TB] clear in run");
    applyStimulus(1'b0, 1'b1, 1'b1);
    cyc(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_lock_lost_cleared", lock_lost, 0);
    checkOutput("t5_ready_kept", ready, 1);

    // Asynchronous reset between edges while in STABLE
    $display("[TB] async reset mid-stable");
    applyStimulus(1'b0, 1'b0, 1'b0);
    cyc(7);
    checkOutput("t6_lock_lost_set", lock_lost, 1);
    checkOutput("t6_pll_rst_wait", pll_rst, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cyc(5);
    checkOutput("t6_ready_stable", ready, 0);
    checkOutput("t6_pll_rst_stable", pll_rst, 0);
    #3;
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("t6_async_pll_rst", pll_rst, 1);
    checkOutput("t6_async_sys_rst", sys_rst, 1);
    checkOutput("t6_async_ready", ready, 0);
    checkOutput("t6_async_lock_lost", lock_lost, 0);
    checkOutput("t6_async_retry", retry_count, 0);
    cyc(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      checkOutput("t6_restart_pll_rst", pll_rst, (k < 4) ? 1 : 0);
    end
    cyc(8);
    checkOutput("t6_ready_early", ready, 0);
    cyc(1);
    checkOutput("t6_ready", ready, 1);

    // Glitch in STABLE: 3-cycle dropout after 5 stable cycles
    $display("[TB] glitch in stable");
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyc(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cyc(10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cyc(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      checkOutput("t3_glitch_ready", ready, 0);
      checkOutput("t3_glitch_pll_rst", pll_rst, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      checkOutput("t3_relock_ready", ready, 0);
      checkOutput("t3_relock_pll_rst", pll_rst, 0);
    end
    cyc(1);
    checkOutput("t3_ready", ready, 1);
    checkOutput("t3_retry", retry_count, 0);
    checkOutput("t3_lock_lost", lock_lost, 0);

    // No lock: 24-cycle retry period, saturation, clear on a timeout edge
    $display("[TB] no lock");
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyc(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7248; k++) begin
      if (k == 7224) applyStimulus(1'b0, 1'b0, 1'b1);
      cyc(1);
      if (k == 7224) applyStimulus(1'b0, 1'b0, 1'b0);
      if (k <= 48) begin
        checkOutput("t2_pll_rst_period", pll_rst, ((k % 24) < 4) ? 1 : 0);
        checkOutput("t2_retry_step", retry_count, k / 24);
      end
      if (k == 6120 || k == 6144 || k == 7200 || k == 7223) begin
        checkOutput("t2_retry_saturated", retry_count, 255);
      end
      if (k == 7224) begin
        checkOutput("t5_clear_on_timeout", retry_count, 0);
        checkOutput("t5_fsm_unaffected", pll_rst, 1);
      end
      if (k == 7248) begin
        checkOutput("t5_retry_after_clear", retry_count, 1);
      end
    end
    checkOutput("t2_ready", ready, 0);
    checkOutput("t2_sys_rst", sys_rst, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
